// File: rtl/arp_table.sv
// ARP cache: learns IP->MAC bindings from the ARP receive parser and answers
// two-stage pipelined lookups. A miss raises a throttled ARP-request trigger.
module arp_table #(
   parameter int unsigned P_ENTRY_NUM   = 8,
   parameter logic [15:0] P_REQ_HOLDOFF = 16'd1000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [47:0] i_recv_target_mac,
   input  logic [31:0] i_recv_target_ip,
   input  logic        i_recv_target_valid,
   input  logic        i_table_clr,
   input  logic [31:0] i_lookup_ip,
   input  logic        i_lookup_valid,
   output logic [47:0] o_lookup_mac,
   output logic        o_lookup_hit,
   output logic        o_lookup_done,
   output logic        o_arp_req,
   output logic [31:0] o_arp_req_ip,
   output logic [4:0]  o_entry_cnt
);

   localparam int unsigned LP_IDX_W = (P_ENTRY_NUM > 1) ? $clog2(P_ENTRY_NUM) : 1;

   // table storage
   logic [P_ENTRY_NUM-1:0] r_valid;
   logic [31:0]            r_ip  [P_ENTRY_NUM];
   logic [47:0]            r_mac [P_ENTRY_NUM];
   logic [LP_IDX_W-1:0]    r_rr_ptr;

   // lookup stage 1
   logic                   r_s1_valid;
   logic [31:0]            r_s1_ip;

   // miss throttle
   logic [31:0]            r_pend_ip;
   logic [15:0]            r_holdoff;

   // learn decision
   logic                   w_learn;
   logic                   w_match_hit;
   logic [LP_IDX_W-1:0]    w_match_idx;
   logic                   w_free_hit;
   logic [LP_IDX_W-1:0]    w_free_idx;
   logic [LP_IDX_W-1:0]    w_wr_idx;

   // stage-2 compare
   logic                   w_lk_hit;
   logic [47:0]            w_lk_mac;
   logic                   w_req;

   assign w_learn = i_recv_target_valid && (i_recv_target_ip != '0);

   // Find an existing entry for the learned IP and the lowest free slot.
   always_comb begin
      w_match_hit = 1'b0;
      w_match_idx = '0;
      w_free_hit  = 1'b0;
      w_free_idx  = '0;
      for (int unsigned i = 0; i < P_ENTRY_NUM; i++) begin
         if (r_valid[i] && (r_ip[i] == i_recv_target_ip) && !w_match_hit) begin
            w_match_hit = 1'b1;
            w_match_idx = LP_IDX_W'(i);
         end
         if (!r_valid[i] && !w_free_hit) begin
            w_free_hit = 1'b1;
            w_free_idx = LP_IDX_W'(i);
         end
      end
   end

   // Priority: refresh the matching entry, else fill a free slot, else evict round-robin.
   always_comb begin
      if (w_match_hit)
         w_wr_idx = w_match_idx;
      else if (w_free_hit)
         w_wr_idx = w_free_idx;
      else
         w_wr_idx = r_rr_ptr;
   end

   // Entry payload; contents are qualified by r_valid so no reset is needed.
   always_ff @(posedge i_clk) begin
      if (w_learn && !i_table_clr) begin
         r_ip[w_wr_idx]  <= i_recv_target_ip;
         r_mac[w_wr_idx] <= i_recv_target_mac;
      end
   end

   // Valid bits, replacement pointer and occupancy; flush beats a learn.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid     <= '0;
         r_rr_ptr    <= '0;
         o_entry_cnt <= '0;
      end else if (i_table_clr) begin
         r_valid     <= '0;
         r_rr_ptr    <= '0;
         o_entry_cnt <= '0;
      end else if (w_learn) begin
         r_valid[w_wr_idx] <= 1'b1;
         if (!w_match_hit && w_free_hit)
            o_entry_cnt <= o_entry_cnt + 5'd1;
         if (!w_match_hit && !w_free_hit)
            r_rr_ptr <= r_rr_ptr + LP_IDX_W'(1);
      end
   end

   // Stage-2 parallel compare; at most one entry can match since duplicates are never stored.
   always_comb begin
      w_lk_hit = 1'b0;
      w_lk_mac = '0;
      for (int unsigned i = 0; i < P_ENTRY_NUM; i++) begin
         if (r_valid[i] && (r_ip[i] == r_s1_ip) && (r_s1_ip != '0)) begin
            w_lk_hit = 1'b1;
            w_lk_mac = w_lk_mac | r_mac[i];
         end
      end
   end

   assign w_req = r_s1_valid && !w_lk_hit &&
                  !((r_holdoff != '0) && (r_s1_ip == r_pend_ip));

   // Lookup pipeline: stage 1 captures the IP, stage 2 registers the result.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1_valid    <= 1'b0;
         r_s1_ip       <= '0;
         o_lookup_done <= 1'b0;
         o_lookup_hit  <= 1'b0;
         o_lookup_mac  <= '0;
      end else begin
         r_s1_valid    <= i_lookup_valid;
         r_s1_ip       <= i_lookup_ip;
         o_lookup_done <= r_s1_valid;
         o_lookup_hit  <= r_s1_valid && w_lk_hit;
         o_lookup_mac  <= (r_s1_valid && w_lk_hit) ? w_lk_mac : '0;
      end
   end

   // Miss throttle: a fresh request reloads the window, flush or learning the pending IP ends it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pend_ip    <= '0;
         r_holdoff    <= '0;
         o_arp_req    <= 1'b0;
         o_arp_req_ip <= '0;
      end else begin
         o_arp_req    <= w_req;
         o_arp_req_ip <= w_req ? r_s1_ip : '0;
         if (w_req) begin
            r_pend_ip <= r_s1_ip;
            r_holdoff <= P_REQ_HOLDOFF;
         end else if (i_table_clr) begin
            r_holdoff <= '0;
         end else if (w_learn && (i_recv_target_ip == r_pend_ip)) begin
            r_holdoff <= '0;
         end else if (r_holdoff != '0) begin
            r_holdoff <= r_holdoff - 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_arp_table.sv
// Testbench for arp_table: directed stimulus, cache model with deadline-based
// request throttling, per-cycle comparison plus literal spot checks.
module tb_arp_table;

   localparam int unsigned N      = 8;
   localparam logic [15:0] HOLD   = 16'd20;
   localparam longint      HOLD_L = 20;

   logic        i_clk;
   logic        i_rst_n;
   logic [47:0] i_recv_target_mac;
   logic [31:0] i_recv_target_ip;
   logic        i_recv_target_valid;
   logic        i_table_clr;
   logic [31:0] i_lookup_ip;
   logic        i_lookup_valid;
   logic [47:0] o_lookup_mac;
   logic        o_lookup_hit;
   logic        o_lookup_done;
   logic        o_arp_req;
   logic [31:0] o_arp_req_ip;
   logic [4:0]  o_entry_cnt;

   arp_table #(
      .P_ENTRY_NUM   (N),
      .P_REQ_HOLDOFF (HOLD)
   ) dut (
      .i_clk               (i_clk),
      .i_rst_n             (i_rst_n),
      .i_recv_target_mac   (i_recv_target_mac),
      .i_recv_target_ip    (i_recv_target_ip),
      .i_recv_target_valid (i_recv_target_valid),
      .i_table_clr         (i_table_clr),
      .i_lookup_ip         (i_lookup_ip),
      .i_lookup_valid      (i_lookup_valid),
      .o_lookup_mac        (o_lookup_mac),
      .o_lookup_hit        (o_lookup_hit),
      .o_lookup_done       (o_lookup_done),
      .o_arp_req           (o_arp_req),
      .o_arp_req_ip        (o_arp_req_ip),
      .o_entry_cnt         (o_entry_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_err    = 0;
   bit cmp_en   = 1'b0;

   // model state
   bit          m_valid [N];
   logic [31:0] m_ip    [N];
   logic [47:0] m_mac   [N];
   int unsigned m_rr;
   int unsigned m_cnt;
   bit          m_s1_v;
   logic [31:0] m_s1_ip;
   logic [31:0] m_pend;
   longint      m_expire;
   longint      m_cyc;

   // expected outputs
   bit          exp_done;
   bit          exp_hit;
   logic [47:0] exp_mac;
   bit          exp_req;
   logic [31:0] exp_req_ip;
   logic [4:0]  exp_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int unsigned i = 0; i < N; i++) begin
         m_valid[i] = 1'b0;
         m_ip[i]    = '0;
         m_mac[i]   = '0;
      end
      m_rr = 0; m_cnt = 0; m_s1_v = 1'b0; m_s1_ip = '0;
      m_pend = '0; m_expire = 0;
      exp_done = 1'b0; exp_hit = 1'b0; exp_mac = '0;
      exp_req = 1'b0; exp_req_ip = '0; exp_cnt = '0;
   endtask

   // One clock edge of the cache's behaviour, using the inputs present at that edge.
   task automatic model_step();
      bit          found;
      bit          placed;
      bit          req;
      logic [47:0] fmac;
      int unsigned slot;
      if (!i_rst_n) begin
         model_reset();
         m_cyc++;
         return;
      end
      found = 1'b0;
      fmac  = '0;
      if (m_s1_ip != 0)
         for (int unsigned i = 0; i < N; i++)
            if (m_valid[i] && m_ip[i] == m_s1_ip) begin
               found = 1'b1;
               fmac  = m_mac[i];
            end
      exp_done = m_s1_v;
      exp_hit  = m_s1_v && found;
      exp_mac  = exp_hit ? fmac : 48'h0;
      req = m_s1_v && !found && !((m_cyc < m_expire) && (m_s1_ip == m_pend));
      exp_req    = req;
      exp_req_ip = req ? m_s1_ip : 32'h0;
      if (req) begin
         m_pend   = m_s1_ip;
         m_expire = m_cyc + HOLD_L + 1;
      end
      if (i_table_clr) begin
         for (int unsigned i = 0; i < N; i++) m_valid[i] = 1'b0;
         m_rr = 0; m_cnt = 0;
         if (!req) m_expire = 0;
      end else if (i_recv_target_valid && i_recv_target_ip != 0) begin
         placed = 1'b0;
         slot   = 0;
         for (int unsigned i = 0; i < N; i++)
            if (!placed && m_valid[i] && m_ip[i] == i_recv_target_ip) begin
               placed = 1'b1; slot = i;
            end
         for (int unsigned i = 0; i < N; i++)
            if (!placed && !m_valid[i]) begin
               placed = 1'b1; slot = i; m_cnt++;
            end
         if (!placed) begin
            slot = m_rr;
            m_rr = (m_rr + 1) % N;
         end
         m_valid[slot] = 1'b1;
         m_ip[slot]    = i_recv_target_ip;
         m_mac[slot]   = i_recv_target_mac;
         if (i_recv_target_ip == m_pend && !req) m_expire = 0;
      end
      exp_cnt = 5'(m_cnt);
      m_s1_v  = i_lookup_valid;
      m_s1_ip = i_lookup_ip;
      m_cyc++;
   endtask

   // Compare every output against the model on each falling edge.
   always @(negedge i_clk) begin
      if (cmp_en) begin
         chk("lookup_done", 64'(o_lookup_done), 64'(exp_done));
         chk("lookup_hit",  64'(o_lookup_hit),  64'(exp_hit));
         chk("lookup_mac",  64'(o_lookup_mac),  64'(exp_mac));
         chk("arp_req",     64'(o_arp_req),     64'(exp_req));
         chk("arp_req_ip",  64'(o_arp_req_ip),  64'(exp_req_ip));
         chk("entry_cnt",   64'(o_entry_cnt),   64'(exp_cnt));
      end
   end

   task automatic step();
      @(posedge i_clk);
      model_step();
      #1;
      i_lookup_valid      = 1'b0;
      i_recv_target_valid = 1'b0;
      i_table_clr         = 1'b0;
   endtask

   task automatic learn_set(input logic [31:0] ip, input logic [47:0] mac);
      i_recv_target_ip    = ip;
      i_recv_target_mac   = mac;
      i_recv_target_valid = 1'b1;
   endtask

   task automatic look_set(input logic [31:0] ip);
      i_lookup_ip    = ip;
      i_lookup_valid = 1'b1;
   endtask

   localparam logic [31:0] IP10 = 32'hC0A8640A;
   localparam logic [31:0] IP20 = 32'hC0A86414;
   localparam logic [31:0] IP30 = 32'hC0A8641E;

   initial begin
      i_rst_n = 1'b0;
      i_recv_target_mac = '0; i_recv_target_ip = '0; i_recv_target_valid = 1'b0;
      i_table_clr = 1'b0; i_lookup_ip = '0; i_lookup_valid = 1'b0;
      m_cyc = 0;
      model_reset();
      step();
      cmp_en = 1'b1;
      step();
      i_rst_n = 1'b1;
      step();
      chk("reset_cnt",  64'(o_entry_cnt), 64'd0);
      chk("reset_done", 64'(o_lookup_done), 64'd0);

      // learn and lookup in the same cycle
      learn_set(IP10, 48'h001122334455);
      look_set(IP10);
      step(); step();
      chk("first_done", 64'(o_lookup_done), 64'd1);
      chk("first_hit",  64'(o_lookup_hit), 64'd1);
      chk("first_mac",  64'(o_lookup_mac), 64'h001122334455);
      chk("first_cnt",  64'(o_entry_cnt), 64'd1);

      // miss and throttle window
      look_set(IP20);
      step(); step();
      chk("miss_hit",    64'(o_lookup_hit), 64'd0);
      chk("miss_mac",    64'(o_lookup_mac), 64'd0);
      chk("miss_req",    64'(o_arp_req), 64'd1);
      chk("miss_req_ip", 64'(o_arp_req_ip), 64'hC0A86414);
      repeat (8) step();
      look_set(IP20);
      step(); step();
      chk("repeat_done", 64'(o_lookup_done), 64'd1);
      chk("repeat_req",  64'(o_arp_req), 64'd0);
      repeat (8) step();
      look_set(IP20);
      step();
      look_set(IP20);
      step();
      chk("window_last_req", 64'(o_arp_req), 64'd0);
      step();
      chk("window_end_req",  64'(o_arp_req), 64'd1);

      // learning the pending IP; flush with simultaneous learn
      repeat (5) step();
      learn_set(IP20, 48'h0A0B0C0D0E0F);
      step();
      look_set(IP20);
      step(); step();
      chk("learned_hit", 64'(o_lookup_hit), 64'd1);
      chk("learned_mac", 64'(o_lookup_mac), 64'h0A0B0C0D0E0F);
      chk("learned_cnt", 64'(o_entry_cnt), 64'd2);
      i_table_clr = 1'b1;
      learn_set(IP30, 48'h00AA00BB00CC);
      step();
      chk("flush_cnt", 64'(o_entry_cnt), 64'd0);
      look_set(IP20);
      step();
      look_set(IP30);
      step();
      chk("flush_miss20_hit", 64'(o_lookup_hit), 64'd0);
      chk("flush_miss20_req", 64'(o_arp_req), 64'd1);
      look_set(IP10);
      step();
      chk("flush_miss30_hit", 64'(o_lookup_hit), 64'd0);
      step();
      chk("flush_miss10_hit", 64'(o_lookup_hit), 64'd0);

      // fill beyond capacity
      for (int unsigned i = 1; i <= 9; i++) begin
         learn_set(32'h0A000000 + i, 48'h020000000000 + 48'(i));
         step();
      end
      chk("full_cnt", 64'(o_entry_cnt), 64'd8);
      look_set(32'h0A000001);
      step();
      look_set(32'h0A000009);
      step();
      chk("evicted_first_hit", 64'(o_lookup_hit), 64'd0);
      step();
      chk("ninth_hit", 64'(o_lookup_hit), 64'd1);
      chk("ninth_mac", 64'(o_lookup_mac), 64'h020000000009);
      learn_set(32'h0A00000A, 48'h02000000000A);
      step();
      look_set(32'h0A000002);
      step();
      look_set(32'h0A000003);
      step();
      chk("tenth_evicts_2", 64'(o_lookup_hit), 64'd0);
      look_set(32'h0A00000A);
      step();
      chk("third_kept", 64'(o_lookup_hit), 64'd1);
      step();
      chk("tenth_mac", 64'(o_lookup_mac), 64'h02000000000A);
      chk("tenth_cnt", 64'(o_entry_cnt), 64'd8);

      // re-learn existing IP; learn of IP 0 is ignored; lookup of IP 0 misses
      learn_set(32'h0A000003, 48'h0300000000AA);
      step();
      learn_set(32'h0, 48'hFFFFFFFFFFFF);
      step();
      look_set(32'h0A000003);
      step();
      look_set(32'h0);
      step();
      chk("relearn_mac", 64'(o_lookup_mac), 64'h0300000000AA);
      chk("relearn_cnt", 64'(o_entry_cnt), 64'd8);
      step();
      chk("ip0_done", 64'(o_lookup_done), 64'd1);
      chk("ip0_hit",  64'(o_lookup_hit), 64'd0);

      // asynchronous reset with two lookups in flight
      look_set(32'h0A000009);
      step();
      look_set(32'h0A00000A);
      step();
      chk("pre_reset_hit", 64'(o_lookup_hit), 64'd1);
      #2;
      i_rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_done", 64'(o_lookup_done), 64'd0);
      chk("async_hit",  64'(o_lookup_hit), 64'd0);
      chk("async_mac",  64'(o_lookup_mac), 64'd0);
      chk("async_cnt",  64'(o_entry_cnt), 64'd0);
      step();
      i_rst_n = 1'b1;
      step();
      chk("no_done_after_reset", 64'(o_lookup_done), 64'd0);
      step();
      chk("no_done_after_reset2", 64'(o_lookup_done), 64'd0);
      look_set(32'h0A000009);
      step(); step();
      chk("post_reset_miss", 64'(o_lookup_hit), 64'd0);
      chk("post_reset_req",  64'(o_arp_req), 64'd1);
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/arp_table.md
# arp_table

ARP cache that sits directly downstream of the ARP receive parser on the 10G MAC path. It learns IP→MAC bindings from the parser's single-cycle sender-address pulses and answers pipelined lookups from the IP transmit path. On a lookup miss it issues a throttled ARP-request trigger to the ARP transmit stage.

## Interface
Parameters:
- P_ENTRY_NUM, 8, number of cache entries (power of two, 2..16)
- P_REQ_HOLDOFF, 16'd1000, cycles during which a repeat miss on the pending request IP is suppressed

Ports:
- i_clk  input  1  sole clock; all logic on rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_recv_target_mac  input  48  learned MAC from ARP parser
- i_recv_target_ip  input  32  learned IP from ARP parser
- i_recv_target_valid  input  1  one-cycle learn strobe
- i_table_clr  input  1  synchronous flush of all entries
- i_lookup_ip  input  32  IP to resolve
- i_lookup_valid  input  1  lookup strobe; may be asserted every cycle
- o_lookup_mac  output  48  resolved MAC, 0 on miss
- o_lookup_hit  output  1  1 = entry found
- o_lookup_done  output  1  one-cycle result strobe
- o_arp_req  output  1  one-cycle ARP-request trigger
- o_arp_req_ip  output  32  IP to request, valid with o_arp_req
- o_entry_cnt  output  5  number of valid entries

## Operation
- Storage: per entry, a valid bit, a 32-bit IP and a 48-bit MAC. There is also a replacement pointer r_rr_ptr of width log2(P_ENTRY_NUM).
- Learn, on a cycle with i_recv_target_valid=1 and i_recv_target_ip != 0. A strobe with IP 0 is ignored.
  - If a valid entry has a matching IP, overwrite its MAC.
  - Else write the lowest-index invalid entry and set its valid bit.
  - Else the table is full: overwrite entry r_rr_ptr, then increment r_rr_ptr modulo P_ENTRY_NUM.
  - Only one entry is written per learn. A duplicate IP never occupies two entries.
- Lookup is a two-stage pipeline.
  - Stage 1 registers i_lookup_ip.
  - Stage 2 compares against all valid entries in parallel and registers the MAC, hit and done outputs.
  - Lookup IP 0 always misses.
- Miss throttle: holds r_pend_ip and a 16-bit down-counter r_holdoff.
  - On a miss, if (r_holdoff != 0 and ip == r_pend_ip), suppress.
  - Otherwise pulse o_arp_req with o_arp_req_ip = ip, load r_pend_ip = ip and load r_holdoff = P_REQ_HOLDOFF.
  - r_holdoff decrements to 0 and saturates there.
  - A learn whose IP equals r_pend_ip clears r_holdoff to 0.
- Flush: i_table_clr clears all valid bits, r_rr_ptr, r_holdoff and o_entry_cnt in one cycle. It has priority over a learn in the same cycle. A lookup in flight completes against the flushed table.
- o_entry_cnt:
  - Increments when a learn fills an invalid entry.
  - Is unchanged on an overwrite.
  - Never exceeds P_ENTRY_NUM.

## Timing
- Reset (i_rst_n=0, asynchronous): all entries invalid; r_rr_ptr=0, r_holdoff=0, r_pend_ip=0. All outputs are 0.
- Learn latency: a strobe in cycle T is visible to the table from cycle T+1.
- Lookup latency: strobe in cycle T gives o_lookup_done=1 in cycle T+2. Throughput is one lookup per cycle with no back-pressure.
- Learn/lookup ordering: a learn in cycle T is visible to a lookup strobed in cycle T, because the stage-2 compare happens in T+1.
- o_arp_req is asserted in the same cycle as the o_lookup_done that reported the miss.
- Back-to-back misses on the same IP within the holdoff window produce exactly one o_arp_req.
- A miss on a different IP during holdoff issues a request immediately and retargets r_pend_ip.
- o_lookup_mac and o_lookup_hit are 0 in every cycle where o_lookup_done=0.
- Reset asserted mid-lookup discards the pipeline; no o_lookup_done follows.

## Test plan
- Learn 192.168.100.10 → 00:11:22:33:44:55 at T; lookup same IP at T → at T+2: done=1, hit=1, mac=0x001122334455, entry_cnt=1.
- Lookup unknown 192.168.100.20 → done=1, hit=0, mac=0, o_arp_req=1 with ip=0xC0A86414. Repeat the lookup 10 cycles later → no o_arp_req. Repeat after P_REQ_HOLDOFF+2 cycles → o_arp_req again.
- Miss on .20, then learn .20 at +5, then lookup .20 → hit. Subsequent miss on .20 after flush → immediate o_arp_req, because the holdoff was cleared by the learn.
- Learn 9 distinct IPs (P_ENTRY_NUM=8) → entry_cnt stays 8. The 1st IP misses and the 9th hits. A 10th learn replaces entry 1.
- Re-learn an existing IP with a new MAC → entry_cnt unchanged; lookup returns the new MAC. A learn with IP 0 leaves the table unchanged.
- i_table_clr together with a learn → entry_cnt=0 and all lookups miss. Async reset mid-lookup → outputs 0 immediately and no done pulse.
